// File: rtl/multiword_add_seq.sv
// multiword_add_seq: streams WORDS-word operands LS-first through an external WIDTH-bit adder
module multiword_add_seq #(
  parameter int WIDTH = 8,
  parameter int WORDS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic             in_cin,
  output logic [WIDTH-1:0] add_x,
  output logic [WIDTH-1:0] add_y,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_last,
  output logic             out_cout
);
  localparam int CW = WORDS > 1 ? $clog2(WORDS) : 1;
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);
  logic [CW-1:0] word_cnt;
  logic carry_q, accept, last;
  // adder drive and handshake; word 0 always takes the fresh transaction carry
  always_comb begin
    last     = word_cnt == LAST;
    add_x    = in_x;
    add_y    = in_y;
    add_cin  = word_cnt == '0 ? in_cin : carry_q;
    in_ready = !flush && (!out_valid || out_ready);
    accept   = in_valid && in_ready;
  end
  // word counter, inter-word carry and the registered output stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt  <= '0;
      carry_q   <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_last  <= 1'b0;
      out_cout  <= 1'b0;
    end else if (flush) begin
      word_cnt  <= '0;
      carry_q   <= 1'b0;
      out_valid <= 1'b0;
    end else if (accept) begin
      word_cnt  <= last ? '0 : word_cnt + CW'(1);
      carry_q   <= add_cout;
      out_valid <= 1'b1;
      out_sum   <= add_sum;
      out_last  <= last;
      out_cout  <= add_cout;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_multiword_add_seq.sv
// tb_multiword_add_seq: randomized and directed checks against a full-precision arithmetic model
module tb_multiword_add_seq;
  localparam int WIDTH = 8;
  localparam int WORDS = 4;
  logic clk = 0, rst_n = 0, flush = 0, in_valid = 0, in_cin = 0, out_ready = 1;
  logic [WIDTH-1:0] in_x = 0, in_y = 0;
  logic in_ready, add_cin, add_cout, out_valid, out_last, out_cout;
  logic [WIDTH-1:0] add_x, add_y, add_sum, out_sum;
  int n_cmp = 0, n_bad = 0;
  logic [WIDTH-1:0] tx_x [WORDS];
  logic [WIDTH-1:0] tx_y [WORDS];
  bit tx_c;
  int m_idx = 0;
  bit m_valid = 0, m_last = 0, m_cout = 0;
  logic [WIDTH-1:0] m_sum = 0;

  multiword_add_seq #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_cin(in_cin), .add_x(add_x), .add_y(add_y),
    .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_last(out_last), .out_cout(out_cout)
  );

  assign {add_cout, add_sum} = {1'b0, add_x} + {1'b0, add_y} + (WIDTH+1)'(add_cin);

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // operands A and B restricted to words 0..n-1, added with the transaction carry
  function automatic logic [63:0] pre(int n);
    logic [63:0] a = 0, b = 0;
    for (int k = 0; k < n; k++) begin
      a |= 64'(tx_x[k]) << (WIDTH * k);
      b |= 64'(tx_y[k]) << (WIDTH * k);
    end
    return a + b + 64'(tx_c);
  endfunction

  task automatic cyc(output bit acc);
    bit rdy;
    logic [63:0] s;
    #1;
    rdy = !flush && (!m_valid || out_ready);
    chk("in_ready", in_ready, rdy);
    chk("add_cin", add_cin, m_idx == 0 ? in_cin : (pre(m_idx) >> (WIDTH * m_idx)) & 1);
    chk("add_x", add_x, in_x);
    acc = in_valid && rdy;
    @(posedge clk);
    if (flush) begin
      m_idx = 0;
      m_valid = 0;
    end else if (acc) begin
      tx_x[m_idx] = in_x;
      tx_y[m_idx] = in_y;
      if (m_idx == 0) tx_c = in_cin;
      s = pre(m_idx + 1);
      m_sum = WIDTH'(s >> (WIDTH * m_idx));
      m_cout = s[WIDTH * (m_idx + 1)];
      m_last = m_idx == WORDS - 1;
      m_valid = 1;
      m_idx = m_idx == WORDS - 1 ? 0 : m_idx + 1;
    end else if (out_ready) m_valid = 0;
    @(negedge clk);
    chk("out_valid", out_valid, m_valid);
    if (m_valid) begin
      chk("out_sum", out_sum, m_sum);
      chk("out_last", out_last, m_last);
      chk("out_cout", out_cout, m_cout);
    end
  endtask

  task automatic drv(bit v, logic [WIDTH-1:0] x, logic [WIDTH-1:0] y, bit c, bit fl, bit ordy, output bit acc);
    in_valid = v;
    in_x = x;
    in_y = y;
    in_cin = c;
    flush = fl;
    out_ready = ordy;
    cyc(acc);
  endtask

  task automatic send_word(logic [WIDTH-1:0] x, logic [WIDTH-1:0] y, bit c);
    bit acc = 0;
    for (int t = 0; t < 20 && !acc; t++) drv(1, x, y, c, 0, 1, acc);
    if (!acc) chk("send_timeout", 1, 0);
  endtask

  task automatic send_tx(logic [31:0] a, logic [31:0] b, bit c);
    for (int i = 0; i < WORDS; i++) send_word(a[WIDTH*i +: WIDTH], b[WIDTH*i +: WIDTH], c);
  endtask

  task automatic idle(int n);
    bit acc;
    for (int i = 0; i < n; i++) drv(0, 0, 0, 0, 0, 1, acc);
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_sum"}, out_sum, 0);
    chk({tag, "_last"}, out_last, 0);
    chk({tag, "_cout"}, out_cout, 0);
  endtask

  initial begin
    bit acc, need, v, fl, ordy, rc;
    logic [31:0] ra, rb;
    int i;
    @(negedge clk);
    #1;
    check_reset_outputs("rst");
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1;
    send_tx(32'h00FFFFFF, 32'h00000001, 0);
    send_tx(32'hFFFFFFFF, 32'h00000001, 0);
    send_tx(32'h00000001, 32'h00000001, 0);
    send_tx(32'h00000000, 32'h00000000, 1);
    idle(2);
    ra = 32'h12FF34FF;
    rb = 32'h01010101;
    send_word(ra[7:0], rb[7:0], 0);
    send_word(ra[15:8], rb[15:8], 0);
    for (int t = 0; t < 3; t++) drv(1, ra[23:16], rb[23:16], 0, 0, 0, acc);
    send_word(ra[23:16], rb[23:16], 0);
    send_word(ra[31:24], rb[31:24], 0);
    send_word(8'hFF, 8'h01, 0);
    send_word(8'hFF, 8'h01, 0);
    drv(1, 8'hFF, 8'h01, 0, 1, 1, acc);
    send_tx(32'h000000FF, 32'h00000000, 0);
    send_word(8'h80, 8'h80, 1);
    send_word(8'hFF, 8'h00, 0);
    #1 rst_n = 0;
    #1 check_reset_outputs("arst");
    m_idx = 0;
    m_valid = 0;
    m_sum = 0;
    #1 rst_n = 1;
    send_tx(32'h000000FF, 32'h00000000, 1);
    idle(1);
    need = 1;
    for (int n = 0; n < 800; n++) begin
      if (m_idx == 0 && need) begin
        ra = $urandom % 3 == 0 ? 32'hFFFFFFFF : $urandom;
        rb = $urandom;
        rc = 1'($urandom % 2);
        need = 0;
      end
      i = m_idx;
      v = $urandom % 4 != 0;
      fl = $urandom % 30 == 0;
      ordy = $urandom % 4 != 0;
      drv(v, ra[WIDTH*i +: WIDTH], rb[WIDTH*i +: WIDTH], rc, fl, ordy, acc);
      if (acc && i == WORDS - 1) need = 1;
    end
    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/multiword_add_seq.md
# multiword_add_seq

Sequencer that performs WORDS×WIDTH-bit addition by streaming operand words, least-significant first, through the team's combinational WIDTH-bit ripple-carry adder. The block sits directly upstream and downstream of that adder: it drives the adder's x/y/cin, captures its sum/cout, and feeds the adder's cout back as cin for the next word. Input and output use valid/ready handshakes, with one registered output stage.

## Interface
- WIDTH, 8: bits per word; must match the attached adder.
- WORDS, 4: words per transaction; legal range ≥1.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous abort of the current transaction.
- in_valid  in  1  operand word pair valid.
- in_ready  out  1  block can accept a word this cycle.
- in_x  in  WIDTH  operand A word.
- in_y  in  WIDTH  operand B word.
- in_cin  in  1  transaction carry-in; sampled only on word 0.
- add_x  out  WIDTH  to adder x.
- add_y  out  WIDTH  to adder y.
- add_cin  out  1  to adder cin.
- add_sum  in  WIDTH  from adder sum.
- add_cout  in  1  from adder cout.
- out_valid  out  1  result word valid.
- out_ready  in  1  downstream accepts the result word.
- out_sum  out  WIDTH  result word.
- out_last  out  1  result word is the final word of its transaction.
- out_cout  out  1  carry out of this word; the transaction carry-out when out_last=1.

## Operation
- State: word_cnt (0..WORDS-1, width max(1,$clog2(WORDS))), carry_q, and output registers out_valid/out_sum/out_last/out_cout.
- Phases: IDLE (word_cnt==0, next accepted word is word 0) and BUSY (word_cnt>0, mid-transaction).
- Adder drive is combinational: add_x=in_x, add_y=in_y, add_cin = (word_cnt==0) ? in_cin : carry_q.
- in_ready = !flush && (!out_valid || out_ready).
- Accept = in_valid && in_ready. On accept:
  - out_sum←add_sum, out_cout←add_cout, out_last←(word_cnt==WORDS-1), out_valid←1, carry_q←add_cout.
  - word_cnt←(word_cnt==WORDS-1) ? 0 : word_cnt+1.
- If there is no accept and out_ready=1, then out_valid←0. The out_sum, out_last and out_cout registers hold their values.
- The final carry never leaks into the next transaction, because word 0 always uses in_cin.
- WORDS=1: every word is word 0 and last. add_cin is always in_cin.
- flush=1: word_cnt←0, carry_q←0, out_valid←0. No accept that cycle, even if in_valid=1. Any pending output word is discarded.
- Arithmetic: unsigned modulo 2^(WORDS·WIDTH). There is no overflow flag beyond out_cout on the last word.

## Timing
- Reset (rst_n low, takes effect immediately): out_valid=0, out_sum=0, out_last=0, out_cout=0, word_cnt=0, carry_q=0. in_ready=1 once flush=0.
- Reset mid-transaction discards partial state. The next accepted word is word 0.
- Latency: a word accepted at edge N appears on out_* after edge N.
- Throughput: 1 word/cycle while out_ready=1.
- The output is stable while out_valid=1 and out_ready=0: out_sum, out_last and out_cout must not change.
- Simultaneous output drain and new accept in the same cycle: out_valid stays 1 and the registers load the new word.
- The combinational path in_x/in_y → adder → out_sum D-input is the critical path and is a single cycle.
- The adder's cout feeds carry_q, which is registered. There is no combinational loop.

## Test plan
- Ripple across words (WIDTH=8, WORDS=4, in_cin=0):
  - Stimulus: x words FF,FF,FF,00 and y words 01,00,00,00, one per cycle, out_ready=1.
  - Required: out_sum 00,00,00,01 and out_cout 1,1,1,0 on consecutive cycles; out_last=1 only on the 4th word.
- Full overflow and carry isolation:
  - Stimulus: transaction FFFFFFFF+00000001, immediately followed by 00000001+00000001 with in_cin=0.
  - Required: first transaction gives sums 00,00,00,00 with final out_cout=1. Second gives 02,00,00,00, so carry_q is not reused on word 0.
- in_cin path:
  - Stimulus: 00000000+00000000 with in_cin=1.
  - Required: out_sum 01,00,00,00; add_cin=1 only while word_cnt==0.
- Backpressure:
  - Stimulus: after word 1 is accepted, hold out_ready=0 for 3 cycles with in_valid=1.
  - Required: in_ready=0 and out_sum/out_last/out_cout are held. On release, words continue with the correct carry and nothing is lost or duplicated.
- Flush mid-transaction:
  - Stimulus: after 2 words of FF+01, assert flush with in_valid=1, then start FF+00 with in_cin=0.
  - Required: no accept during the flush cycle and out_valid=0 after it; the new word 0 yields sum FF, cout 0.
- Async reset mid-transaction:
  - Stimulus: pull rst_n low between edges while word_cnt=2 and out_valid=1.
  - Required: out_valid drops immediately and all outputs read 0. After release, the first accepted word is treated as word 0.
